// File: rtl/adder_vector_checker.sv
// Exhaustive adder checker: walks every {b,a} pair, settles, compares {carry,sum} to a+b.
// Optional ADDER_CHK_STOP_ON_ERR_EN: end the run at the first mismatch, holding the failing operands.
module adder_vector_checker #(
  parameter int WIDTH         = 1,
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_W         = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [WIDTH-1:0]   a,
  output logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   sum,
  input  logic               carry,
  output logic               busy,
  output logic               mismatch,
  output logic [ERR_W-1:0]   err_count,
  output logic [2*WIDTH-1:0] first_fail,
  output logic               done,
  output logic               pass
);

  localparam int VW = 2 * WIDTH;
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LD =
    (SETTLE_CYCLES > 0) ? CW'(SETTLE_CYCLES - 1) : '0;

  typedef enum logic [2:0] {
    IDLE, DRIVE, SETTLE, CHECK, DONE
  } state_t;

  state_t          state, state_n;
  logic [VW-1:0]   vec, vec_n, vinc;
  logic [CW-1:0]   cnt, cnt_n;
  logic [WIDTH-1:0] a_n, b_n;
  logic            busy_n, mm_n, done_n, pass_n;
  logic [ERR_W-1:0] err_n;
  logic [VW-1:0]   ff_n;
  logic [WIDTH:0]  exp_sum;
  logic            bad, last;

  assign exp_sum = {1'b0, a} + {1'b0, b};
  assign bad     = ({carry, sum} != exp_sum);
  assign vinc    = vec + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      vec        <= '0;
      cnt        <= '0;
      a          <= '0;
      b          <= '0;
      busy       <= 1'b0;
      mismatch   <= 1'b0;
      err_count  <= '0;
      first_fail <= '0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      state      <= state_n;
      vec        <= vec_n;
      cnt        <= cnt_n;
      a          <= a_n;
      b          <= b_n;
      busy       <= busy_n;
      mismatch   <= mm_n;
      err_count  <= err_n;
      first_fail <= ff_n;
      done       <= done_n;
      pass       <= pass_n;
    end
  end

  always_comb begin
    state_n = state;
    vec_n   = vec;
    cnt_n   = cnt;
    a_n     = a;
    b_n     = b;
    busy_n  = busy;
    mm_n    = 1'b0;
    err_n   = err_count;
    ff_n    = first_fail;
    done_n  = done;
    pass_n  = pass;
    last    = (vec == {VW{1'b1}});
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          err_n   = '0;
          ff_n    = '0;
          done_n  = 1'b0;
          pass_n  = 1'b0;
          vec_n   = '0;
          a_n     = '0;
          b_n     = '0;
          busy_n  = 1'b1;
          state_n = DRIVE;
        end
      end
      DRIVE: begin
        a_n     = vec[WIDTH-1:0];
        b_n     = vec[VW-1:WIDTH];
        cnt_n   = CNT_LD;
        state_n = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
      end
      SETTLE: begin
        if (cnt == '0) state_n = CHECK;
        else cnt_n = cnt - 1'b1;
      end
      CHECK: begin
        if (bad) begin
          mm_n = 1'b1;
          if (err_count != {ERR_W{1'b1}}) err_n = err_count + 1'b1;
          if (err_count == '0) ff_n = vec;
        end
`ifdef ADDER_CHK_STOP_ON_ERR_EN
        last = last | bad;
`endif
        // terminal check comes before the increment so vec never wraps
        if (last) begin
          state_n = DONE;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          pass_n  = (err_n == '0);
        end else begin
          vec_n   = vinc;
          a_n     = vinc[WIDTH-1:0];
          b_n     = vinc[VW-1:WIDTH];
          state_n = DRIVE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_adder_vector_checker.sv
// Bench: three checker instances against fault-injectable behavioural adders,
// checked against a vector-level reference model.
module tb_adder_vector_checker;

  localparam int W0 = 1, S0 = 1, E0 = 8;
  localparam int W1 = 2, S1 = 0, E1 = 5;
  localparam int W2 = 2, S2 = 2, E2 = 2;
`ifdef ADDER_CHK_STOP_ON_ERR_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [2:0] start = '0;
  always #5 clk = ~clk;

  logic [2:0] flt [3][16];

  logic [W0-1:0] a0, b0, s0;
  logic [W1-1:0] a1, b1, s1;
  logic [W2-1:0] a2, b2, s2;
  logic c0, c1, c2;
  logic [E0-1:0] e0;
  logic [E1-1:0] e1;
  logic [E2-1:0] e2;
  logic [2*W0-1:0] f0;
  logic [2*W1-1:0] f1;
  logic [2*W2-1:0] f2;
  logic [2:0] v_busy, v_mm, v_done, v_pass;
  logic [31:0] v_ab [3];
  logic [31:0] v_err [3];
  logic [31:0] v_ff [3];

  int n_cmp = 0;
  int n_bad = 0;

  always_comb begin
    {c0, s0} = ({1'b0, a0} + {1'b0, b0}) ^ flt[0][{2'b00, b0, a0}][1:0];
    {c1, s1} = ({1'b0, a1} + {1'b0, b1}) ^ flt[1][{b1, a1}];
    {c2, s2} = ({1'b0, a2} + {1'b0, b2}) ^ flt[2][{b2, a2}];
    v_ab[0]  = 32'({b0, a0});
    v_ab[1]  = 32'({b1, a1});
    v_ab[2]  = 32'({b2, a2});
    v_err[0] = 32'(e0);
    v_err[1] = 32'(e1);
    v_err[2] = 32'(e2);
    v_ff[0]  = 32'(f0);
    v_ff[1]  = 32'(f1);
    v_ff[2]  = 32'(f2);
  end

  adder_vector_checker #(.WIDTH(W0), .SETTLE_CYCLES(S0), .ERR_W(E0)) u0 (
    .clk(clk), .reset(reset), .start(start[0]), .a(a0), .b(b0),
    .sum(s0), .carry(c0), .busy(v_busy[0]), .mismatch(v_mm[0]),
    .err_count(e0), .first_fail(f0), .done(v_done[0]), .pass(v_pass[0]));

  adder_vector_checker #(.WIDTH(W1), .SETTLE_CYCLES(S1), .ERR_W(E1)) u1 (
    .clk(clk), .reset(reset), .start(start[1]), .a(a1), .b(b1),
    .sum(s1), .carry(c1), .busy(v_busy[1]), .mismatch(v_mm[1]),
    .err_count(e1), .first_fail(f1), .done(v_done[1]), .pass(v_pass[1]));

  adder_vector_checker #(.WIDTH(W2), .SETTLE_CYCLES(S2), .ERR_W(E2)) u2 (
    .clk(clk), .reset(reset), .start(start[2]), .a(a2), .b(b2),
    .sum(s2), .carry(c2), .busy(v_busy[2]), .mismatch(v_mm[2]),
    .err_count(e2), .first_fail(f2), .done(v_done[2]), .pass(v_pass[2]));

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int wid(input int s);
    return (s == 0) ? W0 : (s == 1) ? W1 : W2;
  endfunction

  function automatic int per(input int s);
    return 2 + ((s == 0) ? S0 : (s == 1) ? S1 : S2);
  endfunction

  function automatic int emax(input int s);
    return (1 << ((s == 0) ? E0 : (s == 1) ? E1 : E2)) - 1;
  endfunction

  function automatic logic [2:0] omask(input int s);
    return 3'((1 << (wid(s) + 1)) - 1);
  endfunction

  task automatic set_clean(input int s);
    for (int v = 0; v < 16; v++) flt[s][v] = '0;
  endtask

  task automatic set_carry_stuck(input int s);
    for (int v = 0; v < 16; v++) begin
      int w = wid(s);
      int av = v & ((1 << w) - 1);
      int bv = (v >> w) & ((1 << w) - 1);
      flt[s][v] = 3'((av + bv) & (1 << w));
    end
  endtask

  task automatic set_all(input int s, input logic [2:0] m);
    for (int v = 0; v < 16; v++) flt[s][v] = m;
  endtask

  task automatic set_rand(input int s);
    for (int v = 0; v < 16; v++)
      flt[s][v] = ($urandom_range(0, 2) == 0) ?
                  (3'($urandom_range(1, 7)) & omask(s)) : 3'b000;
  endtask

  task automatic run(input int s, input bit hold);
    int n, nfail, first, lastv, t, k, pulses, seqbad, ev, p;
    n = 1 << (2 * wid(s));
    p = per(s);
    nfail = 0;
    first = -1;
    for (int v = 0; v < n; v++)
      if ((flt[s][v] & omask(s)) != 0) begin
        nfail++;
        if (first < 0) first = v;
      end
    lastv = (STOP && nfail > 0) ? first : n - 1;
    t = p * (lastv + 1);
    @(negedge clk);
    start[s] = 1'b1;
    @(negedge clk);
    if (!hold) start[s] = 1'b0;
    chk($sformatf("i%0d_start_busy", s), 32'(v_busy[s]), 1);
    chk($sformatf("i%0d_start_done", s), 32'(v_done[s]), 0);
    chk($sformatf("i%0d_start_err", s), v_err[s], 0);
    k = 0;
    pulses = 0;
    seqbad = 0;
    forever begin
      ev = (k / p > lastv) ? lastv : k / p;
      if (v_ab[s] != 32'(ev)) seqbad++;
      if (v_mm[s]) pulses++;
      if (v_done[s] || k > t + 20) break;
      @(negedge clk);
      k++;
    end
    start[s] = 1'b0;
    chk($sformatf("i%0d_done_edge", s), 32'(k), 32'(t));
    chk($sformatf("i%0d_pass", s), 32'(v_pass[s]), 32'(nfail == 0));
    ev = STOP ? (nfail > 0 ? 1 : 0) : (nfail > emax(s) ? emax(s) : nfail);
    chk($sformatf("i%0d_err", s), v_err[s], 32'(ev));
    chk($sformatf("i%0d_first_fail", s), v_ff[s],
        32'(nfail > 0 ? first : 0));
    chk($sformatf("i%0d_pulses", s), 32'(pulses),
        32'(STOP ? (nfail > 0 ? 1 : 0) : nfail));
    chk($sformatf("i%0d_ab_seq", s), 32'(seqbad), 0);
    chk($sformatf("i%0d_busy_end", s), 32'(v_busy[s]), 0);
  endtask

  task automatic chk_reset(input int s, input string tag);
    chk($sformatf("%s_i%0d_ab", tag, s), v_ab[s], 0);
    chk($sformatf("%s_i%0d_busy", tag, s), 32'(v_busy[s]), 0);
    chk($sformatf("%s_i%0d_mm", tag, s), 32'(v_mm[s]), 0);
    chk($sformatf("%s_i%0d_err", tag, s), v_err[s], 0);
    chk($sformatf("%s_i%0d_ff", tag, s), v_ff[s], 0);
    chk($sformatf("%s_i%0d_done", tag, s), 32'(v_done[s]), 0);
    chk($sformatf("%s_i%0d_pass", tag, s), 32'(v_pass[s]), 0);
  endtask

  initial begin
    for (int s = 0; s < 3; s++) set_clean(s);
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) chk_reset(s, "por");
    reset = 1'b0;

    run(0, 1'b0);
    run(0, 1'b0);
    set_carry_stuck(0);
    run(0, 1'b1);
    set_all(1, 3'b001);
    run(1, 1'b0);
    set_all(2, 3'b111);
    run(2, 1'b0);
    set_carry_stuck(2);
    run(2, 1'b1);

    for (int i = 0; i < 9; i++) begin
      set_rand(i % 3);
      run(i % 3, 1'(($urandom_range(0, 1))));
    end

    set_clean(0);
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (2 * per(0) + 1) @(negedge clk);
    #2 reset = 1'b1;
    #1 chk_reset(0, "midrun");
    @(negedge clk);
    reset = 1'b0;
    run(0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
